pll_reconfig_seq: RTL and testbench
===================================

PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

Interface
REQ-001 Parameter NUM_CLOCKS, default 2, number of PLL output counters managed (1..18).
REQ-002 Parameter LOCK_TIMEOUT, default 1000000, refclk cycles allowed for relock before error.
REQ-003 Parameter SETTLE, default 16, refclk cycles after start write during which locked is ignored.
REQ-004 refclk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cfg_wr  in  1  one-cycle strobe writing a shadow-table entry.
REQ-007 cfg_idx  in  5  counter index for cfg_wr.
REQ-008 cfg_data  in  18  counter setting for cfg_wr.
REQ-009 start  in  1  one-cycle strobe launching reconfiguration.
REQ-010 busy  out  1  sequence in progress.
REQ-011 done  out  1  one-cycle pulse on sequence end.
REQ-012 error  out  1  relock timeout flag, sticky until next start.
REQ-013 mgmt_address  out  6  reconfig port address.
REQ-014 mgmt_writedata  out  32  reconfig port write data.
REQ-015 mgmt_write  out  1  reconfig port write request.
REQ-016 mgmt_waitrequest  in  1  reconfig port stall.
REQ-017 pll_locked  in  1  PLL lock status, asynchronous to refclk.

Function
REQ-018 pll_locked SHALL pass through a 2-flop synchronizer; all lock decisions use the synchronized value.
REQ-019 Shadow table: NUM_CLOCKS x 18-bit entries plus NUM_CLOCKS-bit dirty mask; cfg_wr with cfg_idx < NUM_CLOCKS and busy=0 stores cfg_data and sets dirty[cfg_idx]; otherwise cfg_wr ignored.
REQ-020 FSM states: IDLE, MODE, WR_C, STRT, WAIT_WR, SETTLE, WAIT_LOCK, FIN.
REQ-021 IDLE: start with busy=0 and dirty mask nonzero -> MODE, busy=1 next cycle, error cleared.
REQ-022 IDLE: start with dirty mask zero -> no mgmt writes, done=1 on next cycle, busy stays 0.
REQ-023 MODE: write address 0, data 0 (waitrequest mode).
REQ-024 WR_C: for each dirty index in ascending order, write address 5, data {9'b0, idx[4:0], setting[17:0]}; clean indices skipped with no idle cycles between writes.
REQ-025 STRT: write address 2, data 1; then SETTLE for SETTLE cycles, then WAIT_LOCK.
REQ-026 Write handshake: mgmt_write, mgmt_address, mgmt_writedata held stable from assertion until the cycle mgmt_waitrequest=0; write completes that cycle; next write may assert the following cycle.
REQ-027 WAIT_LOCK: synchronized locked=1 -> FIN with error=0, dirty mask cleared; counter reaching LOCK_TIMEOUT first -> FIN with error=1, dirty mask retained.
REQ-028 FIN: done=1 for exactly one cycle, busy=0 same cycle, return to IDLE.
REQ-029 start while busy=1 SHALL be ignored; cfg_wr during busy SHALL be ignored (table frozen).
REQ-030 cfg_wr and start in same IDLE cycle: write is applied first and included in the launched sequence.
REQ-031 mgmt_write SHALL be 0 in all states other than MODE, WR_C, STRT.
REQ-032 Timeout counter width ceil(log2(LOCK_TIMEOUT+1)); no wrap before terminal count.

Reset
REQ-033 rst=1 sampled: next cycle FSM=IDLE, busy=0, done=0, error=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, table and dirty mask cleared, synchronizer cleared.
REQ-034 rst mid-sequence, including during a stalled write, SHALL abort immediately per REQ-033 with no further writes.

Verification
REQ-035 Write idx0=0x00808, idx1=0x01010, start, waitrequest 0 -> writes (0,0),(5,0x00000808),(5,0x00041010),(2,1); locked high after settle -> done pulse, error=0.
REQ-036 Only idx1 dirty, waitrequest held 3 cycles on each write -> exactly 3 writes, each held 4 cycles, stable data.
REQ-037 start with clean table -> zero mgmt writes, done one cycle later, busy never 1.
REQ-038 LOCK_TIMEOUT=100, locked held 0 -> done with error=1 at timeout, dirty mask unchanged; rerun start clears error.
REQ-039 cfg_idx=NUM_CLOCKS and cfg_wr/start during busy -> ignored, sequence unchanged.
REQ-040 rst asserted during stalled WR_C write -> mgmt_write=0 next cycle, busy=0, no done pulse.

Source files
------------

// File: rtl/pll_reconfig_seq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : pll_reconfig_seq                                          |
// | Description : Shadow-table driven PLL counter reconfiguration sequencer |
// |               with settle window and relock timeout.                   |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
module pll_reconfig_seq #(
    parameter int NUM_CLOCKS   = 2,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int SETTLE       = 16
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        cfg_wr,
    input  logic [4:0]  cfg_idx,
    input  logic [17:0] cfg_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    localparam int c_TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int c_SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_TW-1:0] c_TMO_LAST    = c_TW'(LOCK_TIMEOUT - 1);
    localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(SETTLE - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_MODE      = 3'd1;
    localparam logic [2:0] c_WR_C      = 3'd2;
    localparam logic [2:0] c_STRT      = 3'd3;
    localparam logic [2:0] c_WAIT_WR   = 3'd4;
    localparam logic [2:0] c_SETTLE    = 3'd5;
    localparam logic [2:0] c_WAIT_LOCK = 3'd6;
    localparam logic [2:0] c_FIN       = 3'd7;

    logic [2:0]            r_state;
    logic                  r_busy, r_done, r_error, r_wr;
    logic [5:0]            r_addr;
    logic [31:0]           r_data;
    logic                  r_lock_meta, r_lock_sync;
    logic [17:0]           r_table [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] r_dirty;
    logic [4:0]            r_idx;
    logic [c_SW-1:0]       r_settle;
    logic [c_TW-1:0]       r_tmo;

    logic [NUM_CLOCKS-1:0] w_wr_hit;
    logic [NUM_CLOCKS-1:0] w_dirty_next;
    logic [5:0]            w_base;
    logic                  w_found;
    logic [4:0]            w_next_idx;
    logic [17:0]           w_next_set;

    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign mgmt_write     = r_wr;
    assign mgmt_address   = r_addr;
    assign mgmt_writedata = r_data;

    // Out-of-range indices never match, so they fall out of the table write naturally.
    always_comb begin
        w_wr_hit = '0;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            w_wr_hit[i] = cfg_wr && !r_busy && (cfg_idx == 5'(i));
        end
    end

    assign w_dirty_next = r_dirty | w_wr_hit;

    // Lowest dirty index at or above the search base; the base steps past the
    // entry just written so consecutive writes need no idle scan cycles.
    always_comb begin
        w_base     = (r_state == c_WR_C) ? ({1'b0, r_idx} + 6'd1) : 6'd0;
        w_found    = 1'b0;
        w_next_idx = '0;
        w_next_set = '0;
        for (int i = NUM_CLOCKS - 1; i >= 0; i--) begin
            if (r_dirty[i] && (6'(i) >= w_base)) begin
                w_found    = 1'b1;
                w_next_idx = 5'(i);
                w_next_set = r_table[i];
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_dirty     <= '0;
            r_idx       <= '0;
            r_settle    <= '0;
            r_tmo       <= '0;
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
            r_done      <= 1'b0;
            r_dirty     <= w_dirty_next;
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                if (w_wr_hit[i]) begin
                    r_table[i] <= cfg_data;
                end
            end

            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_error <= 1'b0;
                        if (|w_dirty_next) begin
                            r_state <= c_MODE;
                            r_busy  <= 1'b1;
                            r_wr    <= 1'b1;
                            r_addr  <= 6'd0;
                            r_data  <= 32'd0;
                        end else begin
                            r_state <= c_FIN;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_MODE, c_WR_C: begin
                    if (!mgmt_waitrequest) begin
                        if (w_found) begin
                            r_state <= c_WR_C;
                            r_idx   <= w_next_idx;
                            r_addr  <= 6'd5;
                            r_data  <= {9'b0, w_next_idx, w_next_set};
                        end else begin
                            r_state <= c_STRT;
                            r_addr  <= 6'd2;
                            r_data  <= 32'd1;
                        end
                    end
                end
                c_STRT: begin
                    if (!mgmt_waitrequest) begin
                        r_wr    <= 1'b0;
                        r_addr  <= '0;
                        r_data  <= '0;
                        r_state <= c_WAIT_WR;
                    end
                end
                c_WAIT_WR: begin
                    r_settle <= '0;
                    r_state  <= c_SETTLE;
                end
                c_SETTLE: begin
                    if (r_settle == c_SETTLE_LAST) begin
                        r_tmo   <= '0;
                        r_state <= c_WAIT_LOCK;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                c_WAIT_LOCK: begin
                    if (r_lock_sync) begin
                        r_dirty <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_FIN;
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_FIN;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_FIN: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_seq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : tb_pll_reconfig_seq                                       |
// | Description : Vector table plus directed corner sequences.              |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
module tb_pll_reconfig_seq;

    localparam int c_NV = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic [4:0]  cfg_idx;
    logic [17:0] cfg_data;
    logic        start;
    logic        busy, done, error;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write;
    logic        mgmt_waitrequest;
    logic        pll_locked;

    pll_reconfig_seq #(
        .NUM_CLOCKS   (2),
        .LOCK_TIMEOUT (100),
        .SETTLE       (4)
    ) u_dut (
        .refclk           (clk),
        .rst              (rst),
        .cfg_wr           (cfg_wr),
        .cfg_idx          (cfg_idx),
        .cfg_data         (cfg_data),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_write       (mgmt_write),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        mask;
        logic              same;
        logic [17:0]       d0;
        logic [17:0]       d1;
        logic [7:0]        stall;
        logic [2:0]        exp_n;
        logic [3:0][5:0]   ea;
        logic [3:0][31:0]  ed;
    } vec_t;

    vec_t        vecs [c_NV];
    int          tests = 0;
    int          failed = 0;
    int          stall = 0;
    int          wcnt = 0;
    int          done_cnt = 0;
    int          bad_wr = 0;
    int          stab_err = 0;
    int          hold = 0;
    logic        busy_seen = 1'b0;
    logic        p_stalled = 1'b0;
    logic [5:0]  p_addr = '0;
    logic [31:0] p_data = '0;
    logic [37:0] wq [$];
    int          hq [$];

    // Waitrequest responder: stalls each write for `stall` cycles.
    initial begin
        mgmt_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mgmt_write && wcnt < stall) begin
                mgmt_waitrequest = 1'b1;
                wcnt++;
            end else begin
                mgmt_waitrequest = 1'b0;
                wcnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_seen = 1'b1;
        if (mgmt_write && !busy) bad_wr++;
        if (p_stalled && (!mgmt_write || mgmt_address != p_addr || mgmt_writedata != p_data))
            stab_err++;
        if (mgmt_write) begin
            hold++;
            if (!mgmt_waitrequest) begin
                wq.push_back({mgmt_address, mgmt_writedata});
                hq.push_back(hold);
                hold = 0;
            end
        end
        p_stalled = mgmt_write && mgmt_waitrequest;
        p_addr    = mgmt_address;
        p_data    = mgmt_writedata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wq.delete();
        hq.delete();
        done_cnt  = 0;
        bad_wr    = 0;
        stab_err  = 0;
        hold      = 0;
        busy_seen = 1'b0;
        p_stalled = 1'b0;
    endtask

    task automatic cfg(input logic [4:0] idx, input logic [17:0] d);
        cfg_wr = 1'b1; cfg_idx = idx; cfg_data = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done_cnt == 0 && cycles < budget) begin
            tick();
            cycles++;
        end
        check("done_seen", 32'(done_cnt != 0), 32'd1);
        tick();
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int cyc;
        stall = int'(v.stall);
        if (v.mask[0]) cfg(5'd0, v.d0);
        clear_mon();
        if (v.mask[1]) begin
            cfg_wr = 1'b1; cfg_idx = 5'd1; cfg_data = v.d1;
            start = v.same;
            tick();
            cfg_wr = 1'b0; start = 1'b0;
        end
        if (!(v.mask[1] && v.same)) pulse_start();
        check($sformatf("v%0d_busy_first", n), 32'(busy), 32'(v.exp_n != 0));
        check($sformatf("v%0d_done_first", n), 32'(done), 32'(v.exp_n == 0));
        wait_done(300, cyc);
        check($sformatf("v%0d_nwrites", n), 32'(wq.size()), 32'(v.exp_n));
        for (int k = 0; k < wq.size() && k < 4; k++) begin
            check($sformatf("v%0d_addr%0d", n, k), 32'(wq[k][37:32]), 32'(v.ea[k]));
            check($sformatf("v%0d_data%0d", n, k), wq[k][31:0], v.ed[k]);
            check($sformatf("v%0d_hold%0d", n, k), 32'(hq[k]), 32'(v.stall) + 32'd1);
        end
        check($sformatf("v%0d_error", n), 32'(error), 32'd0);
        check($sformatf("v%0d_done_cnt", n), 32'(done_cnt), 32'd1);
        check($sformatf("v%0d_busy_seen", n), 32'(busy_seen), 32'(v.exp_n != 0));
        check($sformatf("v%0d_stable", n), 32'(stab_err), 32'd0);
        check($sformatf("v%0d_wr_outside", n), 32'(bad_wr), 32'd0);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{mask: 2'b11, same: 1'b0, d0: 18'h00808, d1: 18'h01010, stall: 8'd0, exp_n: 3'd4,
                    ea: {6'd2, 6'd5, 6'd5, 6'd0},
                    ed: {32'd1, 32'h00041010, 32'h00000808, 32'd0}};
        vecs[1] = '{mask: 2'b10, same: 1'b0, d0: 18'h0, d1: 18'h3ffff, stall: 8'd3, exp_n: 3'd3,
                    ea: {6'd0, 6'd2, 6'd5, 6'd0},
                    ed: {32'd0, 32'd1, 32'h0007ffff, 32'd0}};
        vecs[2] = '{mask: 2'b01, same: 1'b0, d0: 18'h12345, d1: 18'h0, stall: 8'd1, exp_n: 3'd3,
                    ea: {6'd0, 6'd2, 6'd5, 6'd0},
                    ed: {32'd0, 32'd1, 32'h00012345, 32'd0}};
        vecs[3] = '{mask: 2'b00, same: 1'b0, d0: 18'h0, d1: 18'h0, stall: 8'd0, exp_n: 3'd0,
                    ea: '0, ed: '0};
        vecs[4] = '{mask: 2'b10, same: 1'b1, d0: 18'h0, d1: 18'h00abc, stall: 8'd2, exp_n: 3'd3,
                    ea: {6'd0, 6'd2, 6'd5, 6'd0},
                    ed: {32'd0, 32'd1, 32'h00040abc, 32'd0}};

        rst = 1'b1; cfg_wr = 1'b0; cfg_idx = '0; cfg_data = '0; start = 1'b0; pll_locked = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_write", 32'(mgmt_write), 32'd0);
        check("rst_addr", 32'(mgmt_address), 32'd0);
        check("rst_data", mgmt_writedata, 32'd0);

        pll_locked = 1'b1;
        repeat (3) tick();
        for (int n = 0; n < c_NV; n++) run_vec(n, vecs[n]);

        // Relock timeout, sticky error, retained dirty entry on rerun.
        stall = 0; pll_locked = 1'b0;
        cfg(5'd0, 18'h00555);
        clear_mon();
        pulse_start();
        check("tmo_busy", 32'(busy), 32'd1);
        wait_done(300, cyc);
        check("tmo_error", 32'(error), 32'd1);
        check("tmo_window", 32'(cyc >= 100 && cyc <= 120), 32'd1);
        check("tmo_nwrites", 32'(wq.size()), 32'd3);
        repeat (5) tick();
        check("tmo_sticky", 32'(error), 32'd1);
        pll_locked = 1'b1;
        clear_mon();
        pulse_start();
        check("rerun_err_clr", 32'(error), 32'd0);
        check("rerun_busy", 32'(busy), 32'd1);
        wait_done(300, cyc);
        check("rerun_nwrites", 32'(wq.size()), 32'd3);
        if (wq.size() > 1) check("rerun_entry", {26'd0, wq[1][37:32]} ^ wq[1][31:0], 32'h00000550);
        check("rerun_error", 32'(error), 32'd0);

        // Out-of-range index, and cfg_wr/start while busy.
        cfg(5'd2, 18'h00003);
        clear_mon();
        pulse_start();
        check("badidx_done", 32'(done), 32'd1);
        check("badidx_busy", 32'(busy), 32'd0);
        wait_done(20, cyc);
        stall = 5;
        cfg(5'd0, 18'h00111);
        clear_mon();
        pulse_start();
        repeat (2) tick();
        cfg_wr = 1'b1; cfg_idx = 5'd1; cfg_data = 18'h2aaaa; start = 1'b1;
        tick();
        cfg_wr = 1'b0; start = 1'b0;
        wait_done(300, cyc);
        check("busywr_nwrites", 32'(wq.size()), 32'd3);
        if (wq.size() > 1) check("busywr_entry", wq[1][31:0], 32'h00000111);
        check("busywr_done_cnt", 32'(done_cnt), 32'd1);
        stall = 0;
        clear_mon();
        pulse_start();
        check("busywr_table_clean", 32'(done), 32'd1);
        wait_done(20, cyc);

        // Reset during a stalled counter write.
        stall = 50;
        cfg(5'd0, 18'h00777);
        clear_mon();
        pulse_start();
        cyc = 0;
        while (!(mgmt_write && mgmt_address == 6'd5) && cyc < 200) begin
            tick();
            cyc++;
        end
        check("abort_reached_wrc", 32'(mgmt_write && mgmt_address == 6'd5), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_write", 32'(mgmt_write), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_addr", 32'(mgmt_address), 32'd0);
        check("abort_data", mgmt_writedata, 32'd0);
        clear_mon();
        repeat (20) tick();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_no_writes", 32'(wq.size()), 32'd0);
        stall = 0;
        pulse_start();
        check("abort_table_clr", 32'(done), 32'd1);
        check("abort_busy_after", 32'(busy), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
